depar_seg_sequencer: RTL and testbench

- Sits after the deparser segment-wait stage and its three FIFOs: first-half (segs 0-1), second-half (segs 2-3) and remaining-segs.
- Sequences reads from the three FIFOs and rebuilds each packet as one in-order 256-bit AXI-Stream at the deparser output.
- Discards the stale second-half entry that the upstream stage writes for packets of 1-2 segments.
- Counts emitted packets.

---
 rtl/depar_seg_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_depar_seg_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depar_seg_sequencer.sv
// Deparser segment sequencer: merges first-half, second-half and remaining-seg
// FIFOs into one in-order AXI-Stream, dropping stale second-half entries.
module depar_seg_sequencer #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,

  input  logic [2*C_AXIS_DATA_WIDTH-1:0]    fst_fifo_tdata,
  input  logic [2*C_AXIS_TUSER_WIDTH-1:0]   fst_fifo_tuser,
  input  logic [2*C_AXIS_DATA_WIDTH/8-1:0]  fst_fifo_tkeep,
  input  logic [C_NUM_SEGS/2-1:0]           fst_fifo_tlast,
  input  logic                              fst_fifo_empty,
  output logic                              fst_fifo_rd_en,

  input  logic [2*C_AXIS_DATA_WIDTH-1:0]    snd_fifo_tdata,
  input  logic [2*C_AXIS_TUSER_WIDTH-1:0]   snd_fifo_tuser,
  input  logic [2*C_AXIS_DATA_WIDTH/8-1:0]  snd_fifo_tkeep,
  input  logic [C_NUM_SEGS/2-1:0]           snd_fifo_tlast,
  input  logic                              snd_fifo_empty,
  output logic                              snd_fifo_rd_en,

  input  logic [C_AXIS_DATA_WIDTH-1:0]      rem_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     rem_fifo_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    rem_fifo_tkeep,
  input  logic                              rem_fifo_tlast,
  input  logic                              rem_fifo_empty,
  output logic                              rem_fifo_rd_en,

  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,

  output logic [31:0]                       pkt_cnt
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_FST0,
    S_FST1,
    S_SND0,
    S_SND1,
    S_REM,
    S_DROP_SND
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            free;
  logic            load;
  logic [DW-1:0]   nd;
  logic [UW-1:0]   nu;
  logic [KW-1:0]   nk;
  logic            nl;

  assign free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    nd             = '0;
    nu             = '0;
    nk             = '0;
    nl             = 1'b0;
    fst_fifo_rd_en = 1'b0;
    snd_fifo_rd_en = 1'b0;
    rem_fifo_rd_en = 1'b0;
    if (aresetn && free) begin
      unique case (state)
        S_FST0: begin
          if (!fst_fifo_empty) begin
            load = 1'b1;
            nd   = fst_fifo_tdata[DW-1:0];
            nu   = fst_fifo_tuser[UW-1:0];
            nk   = fst_fifo_tkeep[KW-1:0];
            nl   = fst_fifo_tlast[0];
            if (fst_fifo_tlast[0]) begin
              fst_fifo_rd_en = 1'b1;
              // short packet: the second-half entry is stale, discard it
              snd_fifo_rd_en = !snd_fifo_empty;
              state_nxt = snd_fifo_empty ? S_DROP_SND : S_FST0;
            end else begin
              state_nxt = S_FST1;
            end
          end
        end
        S_FST1: begin
          if (!fst_fifo_empty) begin
            load           = 1'b1;
            nd             = fst_fifo_tdata[2*DW-1:DW];
            nu             = fst_fifo_tuser[2*UW-1:UW];
            nk             = fst_fifo_tkeep[2*KW-1:KW];
            nl             = fst_fifo_tlast[1];
            fst_fifo_rd_en = 1'b1;
            if (fst_fifo_tlast[1]) begin
              snd_fifo_rd_en = !snd_fifo_empty;
              state_nxt = snd_fifo_empty ? S_DROP_SND : S_FST0;
            end else begin
              state_nxt = S_SND0;
            end
          end
        end
        S_SND0: begin
          if (!snd_fifo_empty) begin
            load = 1'b1;
            nd   = snd_fifo_tdata[DW-1:0];
            nu   = snd_fifo_tuser[UW-1:0];
            nk   = snd_fifo_tkeep[KW-1:0];
            nl   = snd_fifo_tlast[0];
            if (snd_fifo_tlast[0]) begin
              snd_fifo_rd_en = 1'b1;
              state_nxt      = S_FST0;
            end else begin
              state_nxt = S_SND1;
            end
          end
        end
        S_SND1: begin
          if (!snd_fifo_empty) begin
            load           = 1'b1;
            nd             = snd_fifo_tdata[2*DW-1:DW];
            nu             = snd_fifo_tuser[2*UW-1:UW];
            nk             = snd_fifo_tkeep[2*KW-1:KW];
            nl             = snd_fifo_tlast[1];
            snd_fifo_rd_en = 1'b1;
            state_nxt      = snd_fifo_tlast[1] ? S_FST0 : S_REM;
          end
        end
        S_REM: begin
          if (!rem_fifo_empty) begin
            load           = 1'b1;
            nd             = rem_fifo_tdata;
            nu             = rem_fifo_tuser;
            nk             = rem_fifo_tkeep;
            nl             = rem_fifo_tlast;
            rem_fifo_rd_en = 1'b1;
            if (rem_fifo_tlast) state_nxt = S_FST0;
          end
        end
        S_DROP_SND: begin
          if (!snd_fifo_empty) begin
            snd_fifo_rd_en = 1'b1;
            state_nxt      = S_FST0;
          end
        end
        default: state_nxt = S_FST0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state         <= S_FST0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= nd;
        m_axis_tuser  <= nu;
        m_axis_tkeep  <= nk;
        m_axis_tlast  <= nl;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_depar_seg_sequencer.sv
// Randomized bench for depar_seg_sequencer: FWFT FIFO models feed the DUT and
// a packet-level beat queue predicts the output stream.
module tb_depar_seg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;
  logic [511:0] fst_fifo_tdata, snd_fifo_tdata;
  logic [255:0] fst_fifo_tuser, snd_fifo_tuser;
  logic [63:0]  fst_fifo_tkeep, snd_fifo_tkeep;
  logic [1:0]   fst_fifo_tlast, snd_fifo_tlast;
  logic         fst_fifo_empty, snd_fifo_empty, rem_fifo_empty;
  logic         fst_fifo_rd_en, snd_fifo_rd_en, rem_fifo_rd_en;
  logic [255:0] rem_fifo_tdata, m_axis_tdata;
  logic [127:0] rem_fifo_tuser, m_axis_tuser;
  logic [31:0]  rem_fifo_tkeep, m_axis_tkeep;
  logic         rem_fifo_tlast, m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [31:0]  pkt_cnt;

  depar_seg_sequencer dut (
    .clk(clk), .aresetn(aresetn),
    .fst_fifo_tdata(fst_fifo_tdata), .fst_fifo_tuser(fst_fifo_tuser),
    .fst_fifo_tkeep(fst_fifo_tkeep), .fst_fifo_tlast(fst_fifo_tlast),
    .fst_fifo_empty(fst_fifo_empty), .fst_fifo_rd_en(fst_fifo_rd_en),
    .snd_fifo_tdata(snd_fifo_tdata), .snd_fifo_tuser(snd_fifo_tuser),
    .snd_fifo_tkeep(snd_fifo_tkeep), .snd_fifo_tlast(snd_fifo_tlast),
    .snd_fifo_empty(snd_fifo_empty), .snd_fifo_rd_en(snd_fifo_rd_en),
    .rem_fifo_tdata(rem_fifo_tdata), .rem_fifo_tuser(rem_fifo_tuser),
    .rem_fifo_tkeep(rem_fifo_tkeep), .rem_fifo_tlast(rem_fifo_tlast),
    .rem_fifo_empty(rem_fifo_empty), .rem_fifo_rd_en(rem_fifo_rd_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  typedef struct {
    logic [511:0] d;
    logic [255:0] u;
    logic [63:0]  k;
    logic [1:0]   l;
    int           t;
  } half_t;

  typedef struct {
    beat_t b;
    int    t;
  } rem_t;

  half_t fq[$];
  half_t sq[$];
  rem_t  rq[$];
  beat_t exp_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int cnt_model = 0;
  int tr_mode = 0;
  int fst_pops = 0, snd_pops = 0, rem_pops = 0;
  bit prev_stall = 0;
  bit chk_b2b = 0;
  bit in_pkt = 0;
  int last_acc = 0;
  beat_t prev_b, last_beat;

  task automatic ck(input bit ok, input string nm,
                    input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic beat_t rbeat(input logic l);
    beat_t b;
    b.d = r256();
    b.u = r256()[127:0];
    b.k = $urandom;
    b.l = l;
    return b;
  endfunction

  task automatic upd_heads();
    fst_fifo_empty = !(fq.size() > 0 && fq[0].t <= cyc);
    snd_fifo_empty = !(sq.size() > 0 && sq[0].t <= cyc);
    rem_fifo_empty = !(rq.size() > 0 && rq[0].t <= cyc);
    fst_fifo_tdata = fq.size() > 0 ? fq[0].d : '0;
    fst_fifo_tuser = fq.size() > 0 ? fq[0].u : '0;
    fst_fifo_tkeep = fq.size() > 0 ? fq[0].k : '0;
    fst_fifo_tlast = fq.size() > 0 ? fq[0].l : '0;
    snd_fifo_tdata = sq.size() > 0 ? sq[0].d : '0;
    snd_fifo_tuser = sq.size() > 0 ? sq[0].u : '0;
    snd_fifo_tkeep = sq.size() > 0 ? sq[0].k : '0;
    snd_fifo_tlast = sq.size() > 0 ? sq[0].l : '0;
    rem_fifo_tdata = rq.size() > 0 ? rq[0].b.d : '0;
    rem_fifo_tuser = rq.size() > 0 ? rq[0].b.u : '0;
    rem_fifo_tkeep = rq.size() > 0 ? rq[0].b.k : '0;
    rem_fifo_tlast = rq.size() > 0 ? rq[0].b.l : 1'b0;
  endtask

  // An n-segment packet as the upstream stage writes it: one fst entry,
  // one snd entry (stale junk when n <= 2), and n-4 rem entries.
  task automatic gen_pkt(input int n, input int dsnd, input int drem,
                         input logic [255:0] d0, input logic [31:0] klast);
    beat_t seg[];
    beat_t junk;
    half_t h;
    rem_t  r;
    int    t;
    seg = new[(n < 4) ? 4 : n];
    for (int i = 0; i < seg.size(); i++) seg[i] = rbeat(i == n - 1);
    if (d0 != '0) seg[0].d = d0;
    if (klast != '0 && n > 4) seg[n-1].k = klast;
    junk = rbeat($urandom_range(1));
    if (n == 1) seg[1] = junk;
    t = cyc + 1;
    if (fq.size() > 0 && fq[$].t > t) t = fq[$].t;
    h.d = {seg[1].d, seg[0].d};
    h.u = {seg[1].u, seg[0].u};
    h.k = {seg[1].k, seg[0].k};
    h.l = {seg[1].l, seg[0].l};
    h.t = t;
    fq.push_back(h);
    if (n <= 2) begin
      seg[2] = rbeat($urandom_range(1));
      seg[3] = rbeat($urandom_range(1));
    end else if (n == 3) begin
      seg[3] = junk;
    end
    t = cyc + 1 + dsnd;
    if (sq.size() > 0 && sq[$].t > t) t = sq[$].t;
    h.d = {seg[3].d, seg[2].d};
    h.u = {seg[3].u, seg[2].u};
    h.k = {seg[3].k, seg[2].k};
    h.l = {seg[3].l, seg[2].l};
    h.t = t;
    sq.push_back(h);
    t = cyc + 1 + drem;
    if (rq.size() > 0 && rq[$].t > t) t = rq[$].t;
    for (int i = 4; i < n; i++) begin
      r.b = seg[i];
      r.t = t;
      rq.push_back(r);
    end
    for (int i = 0; i < n; i++) exp_q.push_back(seg[i]);
  endtask

  task automatic step();
    bit pf, ps, pr;
    beat_t e;
    @(negedge clk);
    cyc++;
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(3) != 0);
      default: m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
    endcase
    upd_heads();
    #2;
    pf = fst_fifo_rd_en;
    ps = snd_fifo_rd_en;
    pr = rem_fifo_rd_en;
    if (!aresetn) begin
      ck(!(pf | ps | pr), "rd_en_in_reset", {pf, ps, pr}, 0);
    end else begin
      ck(pkt_cnt == cnt_model, "pkt_cnt", pkt_cnt, cnt_model);
      ck(!(pf && fst_fifo_empty), "fst_pop_empty", pf, 0);
      ck(!(ps && snd_fifo_empty), "snd_pop_empty", ps, 0);
      ck(!(pr && rem_fifo_empty), "rem_pop_empty", pr, 0);
      if (prev_stall) begin
        ck(m_axis_tvalid, "stall_tvalid_held", m_axis_tvalid, 1);
        ck(m_axis_tdata == prev_b.d && m_axis_tuser == prev_b.u &&
           m_axis_tkeep == prev_b.k && m_axis_tlast == prev_b.l,
           "stall_beat_stable", m_axis_tdata, prev_b.d);
      end
      if (m_axis_tvalid && !m_axis_tready)
        ck(!(pf | ps | pr), "pop_while_stalled", {pf, ps, pr}, 0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          ck(1'b0, "extra_beat", m_axis_tdata, 0);
        end else begin
          e = exp_q.pop_front();
          ck(m_axis_tdata == e.d, "beat_tdata", m_axis_tdata, e.d);
          ck(m_axis_tuser == e.u, "beat_tuser", m_axis_tuser, e.u);
          ck(m_axis_tkeep == e.k, "beat_tkeep", m_axis_tkeep, e.k);
          ck(m_axis_tlast == e.l, "beat_tlast", m_axis_tlast, e.l);
          if (chk_b2b && in_pkt)
            ck(cyc == last_acc + 1, "beat_back_to_back", cyc, last_acc + 1);
          if (e.l) cnt_model++;
          in_pkt = !e.l;
          last_acc = cyc;
          last_beat.d = m_axis_tdata;
          last_beat.u = m_axis_tuser;
          last_beat.k = m_axis_tkeep;
          last_beat.l = m_axis_tlast;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_b.d = m_axis_tdata;
      prev_b.u = m_axis_tuser;
      prev_b.k = m_axis_tkeep;
      prev_b.l = m_axis_tlast;
    end
    @(posedge clk);
    #1;
    if (pf && !fst_fifo_empty) begin void'(fq.pop_front()); fst_pops++; end
    if (ps && !snd_fifo_empty) begin void'(sq.pop_front()); snd_pops++; end
    if (pr && !rem_fifo_empty) begin void'(rq.pop_front()); rem_pops++; end
    upd_heads();
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while ((exp_q.size() + fq.size() + sq.size() + rq.size()) > 0 && b < budget) begin
      step();
      b++;
    end
    ck((exp_q.size() + fq.size() + sq.size() + rq.size()) == 0,
       "drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int k);
    aresetn = 1'b0;
    fq.delete();
    sq.delete();
    rq.delete();
    exp_q.delete();
    cnt_model = 0;
    prev_stall = 0;
    in_pkt = 0;
    upd_heads();
    repeat (k) step();
    aresetn = 1'b1;
  endtask

  initial begin
    int b;
    m_axis_tready = 1'b1;
    aresetn = 1'b0;
    upd_heads();
    repeat (3) step();
    aresetn = 1'b1;
    step();
    ck(m_axis_tvalid == 1'b0, "reset_tvalid", m_axis_tvalid, 0);
    ck(m_axis_tdata == '0, "reset_tdata", m_axis_tdata, 0);
    ck(pkt_cnt == 32'd0, "reset_pkt_cnt", pkt_cnt, 0);

    gen_pkt(1, 0, 0, 256'hA5A5_0001, '0);
    drain(50);
    ck(pkt_cnt == 32'd1, "one_seg_cnt", pkt_cnt, 1);
    ck(last_beat.d == 256'hA5A5_0001, "one_seg_data", last_beat.d, 256'hA5A5_0001);
    ck(last_beat.l == 1'b1, "one_seg_tlast", last_beat.l, 1);
    ck(fst_pops == 1 && snd_pops == 1, "one_seg_pops", {fst_pops, snd_pops}, {32'd1, 32'd1});

    chk_b2b = 1;
    gen_pkt(3, 0, 0, '0, '0);
    drain(50);
    chk_b2b = 0;
    ck(rem_pops == 0, "three_seg_no_rem", rem_pops, 0);
    ck(pkt_cnt == 32'd2, "three_seg_cnt", pkt_cnt, 2);

    gen_pkt(7, 0, 0, '0, 32'h0000_FFFF);
    drain(50);
    ck(last_beat.k == 32'h0000_FFFF, "seven_seg_tkeep", last_beat.k, 32'h0000_FFFF);
    ck(pkt_cnt == 32'd3, "seven_seg_cnt", pkt_cnt, 3);
    ck(rem_pops == 3, "seven_seg_rem_pops", rem_pops, 3);

    gen_pkt(2, 5, 0, '0, '0);
    gen_pkt(1, 0, 0, 256'hC0DE_0002, '0);
    drain(50);
    ck(pkt_cnt == 32'd5, "late_snd_cnt", pkt_cnt, 5);
    ck(last_beat.d == 256'hC0DE_0002, "late_snd_next", last_beat.d, 256'hC0DE_0002);
    ck(snd_pops == 5, "late_snd_pops", snd_pops, 5);

    tr_mode = 2;
    gen_pkt(5, 0, 0, '0, '0);
    drain(100);
    ck(pkt_cnt == 32'd6, "stall_pkt_cnt", pkt_cnt, 6);
    tr_mode = 0;

    gen_pkt(7, 0, 20, '0, '0);
    b = 0;
    while (exp_q.size() > 3 && b < 200) begin
      step();
      b++;
    end
    ck(exp_q.size() == 3, "reach_rem_state", exp_q.size(), 3);
    do_reset(2);
    step();
    ck(m_axis_tvalid == 1'b0, "midpkt_reset_tvalid", m_axis_tvalid, 0);
    ck(pkt_cnt == 32'd0, "midpkt_reset_cnt", pkt_cnt, 0);
    gen_pkt(1, 0, 0, 256'hBEEF_0003, '0);
    drain(50);
    ck(pkt_cnt == 32'd1, "post_reset_cnt", pkt_cnt, 1);
    ck(last_beat.d == 256'hBEEF_0003, "post_reset_data", last_beat.d, 256'hBEEF_0003);

    tr_mode = 1;
    for (int p = 0; p < 300; p++) begin
      gen_pkt($urandom_range(1, 9), $urandom_range(0, 6), $urandom_range(0, 4), '0, '0);
      repeat ($urandom_range(0, 4)) step();
    end
    drain(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
